vblank_update_scheduler: RTL and testbench

Sequences per-frame object state updates (planet position/angle engines) into the vertical blanking interval of the 1080p raster. It watches the pixel/line position from the sync generator, opens a service window at the first blanking cycle, and grants each enabled update engine exclusive access in turn through a req/done handshake. It flags engines that fail to finish before active video resumes, so frame contents never tear mid-scan.

---
 rtl/vblank_update_scheduler.sv | 147 ++++++++++++++
 tb/tb_vblank_update_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/vblank_update_scheduler.sv
// rtl/vblank_update_scheduler.sv - vertical-blanking update scheduler for per-frame object engines
// Grants enabled engines one at a time inside the blanking window and aborts any window still open at frame end.
module vblank_update_scheduler #(
  parameter int N_OBJ     = 8,
  parameter int DISPLAY_H = 1920,
  parameter int TOTAL_H   = 2200,
  parameter int DISPLAY_V = 1080,
  parameter int TOTAL_V   = 1125,
  parameter int TIMEOUT   = 4095
) (
  input  logic             clk1485,
  input  logic             rst,
  input  logic [13:0]      x,
  input  logic [13:0]      y,
  input  logic             enable,
  input  logic [N_OBJ-1:0] obj_en,
  output logic [N_OBJ-1:0] upd_req,
  input  logic [N_OBJ-1:0] upd_done,
  output logic             frame_tick,
  output logic             busy,
  output logic             overrun,
  output logic             timeout_err,
  input  logic             clr_err,
  output logic [15:0]      frame_count
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  // A degenerate raster with no blanking region never opens a window.
  localparam bit CFG_OK = (DISPLAY_H < TOTAL_H) && (DISPLAY_V < TOTAL_V);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t           state, state_n;
  logic [N_OBJ-1:0] mask, mask_n;
  logic [IW-1:0]    idx, idx_n;
  logic [TW-1:0]    tcnt, tcnt_n;
  logic [N_OBJ-1:0] req_n;
  logic             tick_n, busy_n, ovr_n, terr_n;
  logic [15:0]      fc_n;
  logic             trigger, deadline;
  logic [IW-1:0]    first_en, first_rem;

  function automatic logic [IW-1:0] lowest(input logic [N_OBJ-1:0] m);
    lowest = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (m[i]) lowest = IW'(i);
    end
  endfunction

  assign trigger   = CFG_OK && enable && (x == 14'd0) && (y == 14'(DISPLAY_V));
  assign deadline  = (x == 14'(TOTAL_H - 1)) && (y == 14'(TOTAL_V - 1));
  assign first_en  = lowest(obj_en);
  assign first_rem = lowest(mask);

  always_ff @(posedge clk1485) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      idx         <= '0;
      tcnt        <= '0;
      upd_req     <= '0;
      frame_tick  <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      state       <= state_n;
      mask        <= mask_n;
      idx         <= idx_n;
      tcnt        <= tcnt_n;
      upd_req     <= req_n;
      frame_tick  <= tick_n;
      busy        <= busy_n;
      overrun     <= ovr_n;
      timeout_err <= terr_n;
      frame_count <= fc_n;
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    idx_n   = idx;
    tcnt_n  = tcnt;
    req_n   = '0;
    tick_n  = 1'b0;
    ovr_n   = overrun & ~clr_err;
    terr_n  = timeout_err & ~clr_err;
    fc_n    = frame_count;

    case (state)
      IDLE: begin
        if (trigger) begin
          mask_n = obj_en;
          tcnt_n = '0;
          tick_n = 1'b1;
          if (|obj_en) begin
            state_n = GRANT;
            idx_n   = first_en;
            req_n   = N_OBJ'(1) << first_en;
          end else begin
            state_n = GAP;
          end
        end
      end
      GRANT: begin
        req_n = upd_req;
        if (upd_done[idx] || tcnt == TMAX) begin
          if (!upd_done[idx]) terr_n = 1'b1;
          mask_n[idx] = 1'b0;
          req_n       = '0;
          state_n     = GAP;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      GAP: begin
        tcnt_n = '0;
        if (|mask) begin
          state_n = GRANT;
          idx_n   = first_rem;
          req_n   = N_OBJ'(1) << first_rem;
        end else begin
          state_n = IDLE;
          fc_n    = frame_count + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Active video is about to resume: drop everything rather than let an update tear the frame.
    if (state != IDLE && deadline) begin
      state_n = IDLE;
      mask_n  = '0;
      req_n   = '0;
      tick_n  = 1'b0;
      ovr_n   = 1'b1;
      fc_n    = frame_count;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_vblank_update_scheduler.sv
// tb/tb_vblank_update_scheduler.sv - directed self-checking bench for vblank_update_scheduler
module tb_vblank_update_scheduler;

  logic        clk1485 = 1'b0;
  logic        rst;
  logic [13:0] x, y;
  logic        enable;
  logic [3:0]  obj_en;
  logic [3:0]  upd_req;
  logic [3:0]  upd_done;
  logic        frame_tick, busy, overrun, timeout_err, clr_err;
  logic [15:0] frame_count;

  int n_chk = 0;
  int n_err = 0;

  vblank_update_scheduler #(
    .N_OBJ(4), .DISPLAY_H(1920), .TOTAL_H(2200),
    .DISPLAY_V(1080), .TOTAL_V(1125), .TIMEOUT(15)
  ) dut (
    .clk1485(clk1485), .rst(rst), .x(x), .y(y), .enable(enable),
    .obj_en(obj_en), .upd_req(upd_req), .upd_done(upd_done),
    .frame_tick(frame_tick), .busy(busy), .overrun(overrun),
    .timeout_err(timeout_err), .clr_err(clr_err), .frame_count(frame_count)
  );

  always #5 clk1485 = ~clk1485;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1485);
    #1;
  endtask

  task automatic fire_trigger();
    x = 14'd0;
    y = 14'd1080;
    step();
    x = 14'd5;
    y = 14'd5;
  endtask

  task automatic serve(input int i, input string tag);
    chk({tag, "_req"}, upd_req, 32'(4'b0001 << i));
    chk({tag, "_busy"}, busy, 1);
    step();
    step();
    upd_done = 4'b0001 << i;
    step();
    upd_done = 4'b0000;
    chk({tag, "_gap"}, upd_req, 0);
    step();
  endtask

  int held;

  initial begin
    rst = 1'b1; x = 14'd5; y = 14'd5; enable = 1'b0;
    obj_en = 4'b0000; upd_done = 4'b0000; clr_err = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_req", upd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_fc", frame_count, 0);

    // normal window 1011
    enable = 1'b1;
    obj_en = 4'b1011;
    fire_trigger();
    chk("n_tick", frame_tick, 1);
    serve(0, "n0");
    chk("n_tick_off", frame_tick, 0);
    serve(1, "n1");
    serve(3, "n3");
    chk("n_busy_end", busy, 0);
    chk("n_fc", frame_count, 1);
    chk("n_terr", timeout_err, 0);
    chk("n_ovr", overrun, 0);

    // empty mask
    obj_en = 4'b0000;
    fire_trigger();
    chk("e_tick", frame_tick, 1);
    chk("e_busy", busy, 1);
    chk("e_req", upd_req, 0);
    step();
    chk("e_tick_off", frame_tick, 0);
    chk("e_busy_off", busy, 0);
    chk("e_fc", frame_count, 2);

    // disabled trigger, spurious done, retrigger, enable drop mid-window
    enable = 1'b0;
    obj_en = 4'b0101;
    fire_trigger();
    chk("d_tick", frame_tick, 0);
    chk("d_busy", busy, 0);
    enable = 1'b1;
    fire_trigger();
    chk("s_req0", upd_req, 4'b0001);
    upd_done = 4'b0100;
    step();
    upd_done = 4'b0000;
    chk("s_spur", upd_req, 4'b0001);
    fire_trigger();
    chk("s_retrig_tick", frame_tick, 0);
    chk("s_retrig_req", upd_req, 4'b0001);
    enable = 1'b0;
    upd_done = 4'b0001;
    step();
    upd_done = 4'b0000;
    chk("s_gap", upd_req, 0);
    step();
    serve(2, "s2");
    chk("s_busy_end", busy, 0);
    chk("s_fc", frame_count, 3);
    enable = 1'b1;

    // timeout on engine 1, engine 3 still served
    obj_en = 4'b1010;
    fire_trigger();
    held = 0;
    while (upd_req[1] && held < 40) begin
      held++;
      step();
    end
    chk("t_held", held, 16);
    chk("t_gap", upd_req, 0);
    chk("t_terr", timeout_err, 1);
    step();
    serve(3, "t3");
    chk("t_fc", frame_count, 4);
    chk("t_terr_sticky", timeout_err, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t_clr", timeout_err, 0);

    // overrun: deadline while engine 0 still granted
    obj_en = 4'b0001;
    fire_trigger();
    chk("o_req", upd_req, 4'b0001);
    step();
    step();
    x = 14'd2199;
    y = 14'd1124;
    clr_err = 1'b1;
    step();
    x = 14'd5;
    y = 14'd5;
    clr_err = 1'b0;
    chk("o_req_drop", upd_req, 0);
    chk("o_ovr", overrun, 1);
    chk("o_busy", busy, 0);
    chk("o_fc", frame_count, 4);
    chk("o_terr", timeout_err, 0);
    step();
    chk("o_ovr_sticky", overrun, 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("o_clr", overrun, 0);

    // reset mid-grant
    obj_en = 4'b1011;
    fire_trigger();
    chk("r_req", upd_req, 4'b0001);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r_req0", upd_req, 0);
    chk("r_busy", busy, 0);
    chk("r_tick", frame_tick, 0);
    chk("r_fc", frame_count, 0);
    step();
    step();
    chk("r_idle", upd_req, 0);
    chk("r_idle_busy", busy, 0);
    fire_trigger();
    chk("r_regrant", upd_req, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
